// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one single-port RAM controller between fetch and load/store
// One request in flight; bad requests are answered with err=1 and never reach RAM.
module mem_arbiter #(
  parameter int unsigned MEM_BYTES  = 1024,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req_valid,
  output logic        i_req_ready,
  input  logic [31:0] i_req_addr,
  output logic        i_rsp_valid,
  output logic [31:0] i_rsp_rdata,
  output logic        i_rsp_err,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic [31:0] d_req_addr,
  input  logic        d_req_we,
  input  logic [1:0]  d_req_size,
  input  logic [31:0] d_req_wdata,
  output logic        d_rsp_valid,
  output logic [31:0] d_rsp_rdata,
  output logic        d_rsp_err,
  output logic [31:0] mem_addr,
  output logic [1:0]  mem_size,
  output logic        mem_rw,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned   CW        = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(STARVE_MAX);
  localparam logic [31:0]   MEM_LIMIT = 32'(MEM_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_RESP} state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic [31:0]   addr_q, addr_d;
  logic [1:0]    size_q, size_d;
  logic          we_q, we_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [CW-1:0] starve_q, starve_d;
  logic [31:0]   i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic          i_err_q, i_err_d, d_err_q, d_err_d;

  logic          can_grant, fetch_first, d_grant, i_grant;
  logic [31:0]   sel_addr, sel_wdata;
  logic [1:0]    sel_size;
  logic          sel_we, sel_err;
  logic          rsp_load, rsp_owner, rsp_err;
  logic [31:0]   rsp_data;

  function automatic logic [31:0] size_mask(input logic [1:0] size, input logic [31:0] value);
    case (size)
      2'b01:   return {24'h0, value[7:0]};
      2'b10:   return {16'h0, value[15:0]};
      default: return value;
    endcase
  endfunction

  assign can_grant   = (state_q == S_IDLE) || (state_q == S_RESP);
  assign fetch_first = i_req_valid && (starve_q == CNT_MAX);
  assign d_grant     = can_grant && d_req_valid && !fetch_first;
  assign i_grant     = can_grant && i_req_valid && !d_grant;

  assign sel_addr  = d_grant ? d_req_addr : i_req_addr;
  assign sel_size  = d_grant ? d_req_size : 2'b11;
  assign sel_we    = d_grant && d_req_we;
  assign sel_wdata = d_grant ? size_mask(d_req_size, d_req_wdata) : 32'h0;
  assign sel_err   = (sel_addr >= MEM_LIMIT) || (sel_size == 2'b00) ||
                     ((sel_size == 2'b10) && sel_addr[0]) ||
                     ((sel_size == 2'b11) && (sel_addr[1:0] != 2'b00));

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    size_d    = size_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    starve_d  = starve_q;
    i_rdata_d = i_rdata_q;
    i_err_d   = i_err_q;
    d_rdata_d = d_rdata_q;
    d_err_d   = d_err_q;
    rsp_load  = 1'b0;
    rsp_owner = owner_q;
    rsp_data  = 32'h0;
    rsp_err   = 1'b0;

    case (state_q)
      S_IDLE, S_RESP: begin
        if (d_grant || i_grant) begin
          owner_d = d_grant;
          if (sel_err) begin
            // Rejected requests skip RAM entirely and answer on the next cycle.
            state_d   = S_RESP;
            rsp_load  = 1'b1;
            rsp_owner = d_grant;
            rsp_err   = 1'b1;
          end else begin
            state_d = S_ISSUE;
            addr_d  = sel_addr;
            size_d  = sel_size;
            we_d    = sel_we;
            wdata_d = sel_wdata;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (we_q) begin
          state_d  = S_RESP;
          rsp_load = 1'b1;
        end else begin
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        state_d  = S_RESP;
        rsp_load = 1'b1;
        rsp_data = size_mask(size_q, mem_rdata);
      end
      default: state_d = S_IDLE;
    endcase

    if (rsp_load) begin
      if (rsp_owner) begin
        d_rdata_d = rsp_data;
        d_err_d   = rsp_err;
      end else begin
        i_rdata_d = rsp_data;
        i_err_d   = rsp_err;
      end
    end

    if (i_grant || !i_req_valid) begin
      starve_d = '0;
    end else if (d_grant && (starve_q != CNT_MAX)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      owner_q   <= 1'b0;
      addr_q    <= 32'h0;
      size_q    <= 2'b00;
      we_q      <= 1'b0;
      wdata_q   <= 32'h0;
      starve_q  <= '0;
      i_rdata_q <= 32'h0;
      i_err_q   <= 1'b0;
      d_rdata_q <= 32'h0;
      d_err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      starve_q  <= starve_d;
      i_rdata_q <= i_rdata_d;
      i_err_q   <= i_err_d;
      d_rdata_q <= d_rdata_d;
      d_err_q   <= d_err_d;
    end
  end

  assign i_req_ready = i_grant;
  assign d_req_ready = d_grant;
  assign i_rsp_valid = (state_q == S_RESP) && !owner_q;
  assign d_rsp_valid = (state_q == S_RESP) && owner_q;
  assign i_rsp_rdata = i_rdata_q;
  assign i_rsp_err   = i_err_q;
  assign d_rsp_rdata = d_rdata_q;
  assign d_rsp_err   = d_err_q;

  // Bus is only driven while a command is live, so a write can never repeat.
  assign mem_size  = ((state_q == S_ISSUE) || (state_q == S_CAPTURE)) ? size_q : 2'b00;
  assign mem_addr  = ((state_q == S_ISSUE) || (state_q == S_CAPTURE)) ? addr_q : 32'h0;
  assign mem_rw    = (state_q == S_ISSUE) && we_q;
  assign mem_wdata = ((state_q == S_ISSUE) && we_q) ? wdata_q : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter
// Reference model: byte array plus access rules; RAM device model behind the bus.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req_valid, i_req_ready, i_rsp_valid, i_rsp_err;
  logic [31:0] i_req_addr, i_rsp_rdata;
  logic        d_req_valid, d_req_ready, d_req_we, d_rsp_valid, d_rsp_err;
  logic [1:0]  d_req_size;
  logic [31:0] d_req_addr, d_req_wdata, d_rsp_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_size;
  logic        mem_rw;

  int checks = 0;
  int errors = 0;

  logic [7:0]  ram     [0:1023];
  logic [7:0]  ref_mem [0:1023];
  logic [31:0] ram_q;
  logic        preload;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_BYTES(1024), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_rsp_valid(i_rsp_valid), .i_rsp_rdata(i_rsp_rdata), .i_rsp_err(i_rsp_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_we(d_req_we), .d_req_size(d_req_size), .d_req_wdata(d_req_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata), .d_rsp_err(d_rsp_err),
    .mem_addr(mem_addr), .mem_size(mem_size), .mem_rw(mem_rw),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic int nbytes(input logic [1:0] s);
    case (s)
      2'b01:   return 1;
      2'b10:   return 2;
      2'b11:   return 4;
      default: return 0;
    endcase
  endfunction

  // RAM controller: registered read of 4 bytes, sized write.
  assign mem_rdata = ram_q;
  always @(posedge clk) begin
    if (preload) begin
      for (int k = 0; k < 1024; k++) ram[k] = 8'h00;
      {ram[3], ram[2], ram[1], ram[0]} = 32'h00a00193;
    end else if (mem_size != 2'b00) begin
      if (mem_rw) begin
        for (int k = 0; k < nbytes(mem_size); k++)
          ram[mem_addr[9:0] + 10'(k)] = mem_wdata[8*k +: 8];
      end else begin
        ram_q <= {ram[mem_addr[9:0] + 10'd3], ram[mem_addr[9:0] + 10'd2],
                  ram[mem_addr[9:0] + 10'd1], ram[mem_addr[9:0]]};
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_err(input logic [31:0] a, input logic [1:0] s);
    return (a >= 32'd1024) || (s == 2'b00) || (s == 2'b10 && a % 2 != 0) ||
           (s == 2'b11 && a % 4 != 0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] s);
    logic [31:0] v = 32'h0;
    for (int k = 0; k < nbytes(s); k++) v = v + (32'(ref_mem[(a + k) % 1024]) << (8 * k));
    return v;
  endfunction

  task automatic do_req(input bit is_d, input logic [31:0] a, input bit we,
                        input logic [1:0] s, input logic [31:0] wd, output logic [31:0] got);
    logic        e;
    logic [1:0]  es;
    int          n, exp_lat;
    bit          seen, touched;
    logic [31:0] exp_d;
    es      = is_d ? s : 2'b11;
    e       = exp_err(a, es);
    exp_lat = e ? 1 : ((is_d && we) ? 2 : 3);
    exp_d   = (e || (is_d && we)) ? 32'h0 : ref_load(a, es);
    @(negedge clk);
    if (is_d) begin
      d_req_valid = 1'b1; d_req_addr = a; d_req_we = we; d_req_size = s; d_req_wdata = wd;
    end else begin
      i_req_valid = 1'b1; i_req_addr = a;
    end
    #1;
    n = 0;
    while (!(is_d ? d_req_ready : i_req_ready) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check_eq("accept", 32'(n < 20), 32'd1);
    @(posedge clk); #1;
    d_req_valid = 1'b0;
    i_req_valid = 1'b0;
    n = 0; seen = 0; touched = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (mem_size != 2'b00) touched = 1;
      seen = is_d ? d_rsp_valid : i_rsp_valid;
    end
    check_eq("latency", n, exp_lat);
    got = is_d ? d_rsp_rdata : i_rsp_rdata;
    check_eq("rdata", got, exp_d);
    check_eq("err", 32'(is_d ? d_rsp_err : i_rsp_err), 32'(e));
    check_eq("ram_touched", 32'(touched), 32'(!e));
    @(negedge clk);
    check_eq("single_pulse", 32'(is_d ? d_rsp_valid : i_rsp_valid), 32'd0);
    if (is_d && we && !e)
      for (int k = 0; k < nbytes(s); k++) ref_mem[(a + k) % 1024] = wd[8*k +: 8];
  endtask

  initial begin
    logic [31:0] got, a;
    logic [1:0]  s;
    bit          is_d;
    int          g, cyc, issued, rcvd, pulses;
    bit          both;
    bit          grant_seq [10];
    int          acc_cyc [$];
    logic [31:0] expq [$];

    rst_n = 1'b0; preload = 1'b1;
    i_req_valid = 0; i_req_addr = 0;
    d_req_valid = 0; d_req_addr = 0; d_req_we = 0; d_req_size = 0; d_req_wdata = 0;
    for (int k = 0; k < 1024; k++) ref_mem[k] = 8'h00;
    {ref_mem[3], ref_mem[2], ref_mem[1], ref_mem[0]} = 32'h00a00193;
    repeat (3) @(negedge clk);
    check_eq("rst_mem_size", 32'(mem_size), 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'h0);
    check_eq("rst_mem_rw", 32'(mem_rw), 32'd0);
    check_eq("rst_rsp_valid", 32'({i_rsp_valid, d_rsp_valid}), 32'd0);
    check_eq("rst_rdata", i_rsp_rdata | d_rsp_rdata, 32'h0);
    preload = 1'b0; rst_n = 1'b1;
    @(negedge clk);

    do_req(1, 32'h0, 0, 2'b11, 32'h0, got);
    check_eq("load_word0", got, 32'h00a00193);
    do_req(1, 32'h5, 1, 2'b01, 32'hFFFF_FFAB, got);
    do_req(1, 32'h4, 0, 2'b10, 32'h0, got);
    check_eq("load_half4", got, 32'h0000AB00);
    do_req(1, 32'h2,   0, 2'b11, 32'h0, got);
    do_req(1, 32'h3,   0, 2'b10, 32'h0, got);
    do_req(1, 32'h400, 0, 2'b11, 32'h0, got);
    do_req(1, 32'h8,   0, 2'b00, 32'h0, got);
    do_req(0, 32'h6,   0, 2'b11, 32'h0, got);

    // Both requesters continuously valid: four data grants, then one fetch.
    @(negedge clk);
    i_req_valid = 1; i_req_addr = 32'h0;
    d_req_valid = 1; d_req_addr = 32'h0; d_req_we = 0; d_req_size = 2'b11;
    g = 0; cyc = 0; both = 0;
    while (g < 10 && cyc < 200) begin
      #1;
      if (i_req_ready && d_req_ready) both = 1;
      if (d_req_ready || i_req_ready) begin
        grant_seq[g] = d_req_ready;
        g++;
      end
      @(negedge clk);
      cyc++;
    end
    i_req_valid = 0; d_req_valid = 0;
    check_eq("starve_grants", g, 10);
    check_eq("starve_exclusive", 32'(both), 32'd0);
    for (int k = 0; k < 10; k++) check_eq("starve_seq", 32'(grant_seq[k]), 32'(k % 5 != 4));
    repeat (6) @(negedge clk);

    // Back-to-back fetches.
    i_req_valid = 1; i_req_addr = 32'h0;
    issued = 0; rcvd = 0; cyc = 0; pulses = 0;
    while (rcvd < 3 && cyc < 40) begin
      #1;
      if (i_rsp_valid) begin
        pulses++;
        if (expq.size() == 0) check_eq("b2b_extra_pulse", 32'd1, 32'd0);
        else check_eq("b2b_rdata", i_rsp_rdata, expq.pop_front());
        rcvd++;
      end
      if (i_req_valid && i_req_ready) begin
        acc_cyc.push_back(cyc);
        expq.push_back(ref_load(32'(4 * issued), 2'b11));
        issued++;
      end
      @(posedge clk); #1;
      if (issued == 3) i_req_valid = 0;
      else i_req_addr = 32'(4 * issued);
      @(negedge clk);
      cyc++;
    end
    i_req_valid = 0;
    check_eq("b2b_rcvd", rcvd, 3);
    if (acc_cyc.size() == 3) begin
      check_eq("b2b_gap1", acc_cyc[1] - acc_cyc[0], 3);
      check_eq("b2b_gap2", acc_cyc[2] - acc_cyc[1], 3);
    end else begin
      check_eq("b2b_accepts", acc_cyc.size(), 3);
    end
    repeat (3) begin
      @(negedge clk);
      if (i_rsp_valid) pulses++;
    end
    check_eq("b2b_pulses", pulses, 3);

    // Reset during CAPTURE of a load.
    @(negedge clk);
    d_req_valid = 1; d_req_addr = 32'h0; d_req_we = 0; d_req_size = 2'b11;
    #1;
    check_eq("rst_mid_accept", 32'(d_req_ready), 32'd1);
    @(posedge clk); #1;
    d_req_valid = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 0;
    #1;
    check_eq("rst_mid_size", 32'(mem_size), 32'd0);
    check_eq("rst_mid_addr", mem_addr, 32'h0);
    check_eq("rst_mid_rdata", d_rsp_rdata, 32'h0);
    check_eq("rst_mid_valid", 32'({d_rsp_valid, d_rsp_err}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    pulses = 0;
    repeat (5) begin
      @(negedge clk);
      if (d_rsp_valid) pulses++;
    end
    check_eq("rst_mid_no_rsp", pulses, 0);
    do_req(1, 32'h0, 0, 2'b11, 32'h0, got);
    check_eq("rst_mid_after", got, 32'h00a00193);

    for (int it = 0; it < 120; it++) begin
      is_d = ($urandom % 4) != 0;
      s    = 2'($urandom % 4);
      if ($urandom % 10 == 0) a = 32'd1024 + ($urandom % 64);
      else begin
        a = $urandom % 1024;
        if ($urandom % 4 != 0) begin
          if (s == 2'b10 || !is_d) a = a & ~32'h1;
          if (s == 2'b11 || !is_d) a = a & ~32'h3;
        end
      end
      do_req(is_d, a, 1'($urandom % 2), s, $urandom, got);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
